// File: rtl/rect_plotter.sv
// rect_plotter
//
// Rasterises one axis-aligned rectangle per accepted request into a stream
// of single-pixel writes (one per clock) for the VGA adapter. Filled and
// outline-only modes are supported, and pixels outside the visible
// SCREEN_W x SCREEN_H area are suppressed (plot=0) without shortening the scan.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so a request held
// valid through a draw is accepted exactly once, after the block returns to
// IDLE. All req_* fields are captured at acceptance and ignored afterwards.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake
//   req_x, req_y           top-left corner
//   req_w, req_h           size in pixels (either 0 -> empty rectangle)
//   req_colour             pixel colour
//   req_outline            1 = border pixels only, 0 = filled
//   x, y, colour, plot     pixel write to the VGA adapter
//   busy                   high in DRAW and DONE
//   done                   one-cycle completion pulse
//   dbg_state              current FSM state (IDLE=0, DRAW=1, DONE=2)
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  input  logic [X_W-1:0] req_w,
  input  logic [Y_W-1:0] req_h,
  input  logic [C_W-1:0] req_colour,
  input  logic           req_outline,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           done,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Screen limits at the widened sum width so a carry-out is automatically
  // treated as off-screen by the same compare.
  localparam logic [X_W:0] SCR_W_L = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] SCR_H_L = SCREEN_H[Y_W:0];

  state_t state, state_nxt;

  // Latched request
  logic [X_W-1:0] x0_r;
  logic [Y_W-1:0] y0_r;
  logic [X_W-1:0] w_r;
  logic [Y_W-1:0] h_r;
  logic           outline_r;

  // Offset of the pixel currently presented on x/y
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;

  logic           accept;
  logic           empty_req;
  logic           row_end;
  logic           last_px;
  logic [X_W-1:0] ncx;
  logic [Y_W-1:0] ncy;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           next_on;
  logic           next_border;
  logic           first_on;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  assign accept    = req_valid && req_ready;
  assign empty_req = (req_w == '0) || (req_h == '0);

  // Scan stepping: next pixel offsets in row-major order
  assign row_end = (cx == w_r - 1'b1);
  assign last_px = row_end && (cy == h_r - 1'b1);
  assign ncx     = row_end ? '0 : cx + 1'b1;
  assign ncy     = row_end ? cy + 1'b1 : cy;

  assign sum_x   = {1'b0, x0_r} + {1'b0, ncx};
  assign sum_y   = {1'b0, y0_r} + {1'b0, ncy};
  assign next_on = (sum_x < SCR_W_L) && (sum_y < SCR_H_L);
  assign next_border = !outline_r || (ncx == '0) || (ncx == w_r - 1'b1) ||
                       (ncy == '0) || (ncy == h_r - 1'b1);

  // The first pixel sits at offset (0,0), which is always a border pixel,
  // so only the on-screen test matters for it.
  assign first_on = ({1'b0, req_x} < SCR_W_L) && ({1'b0, req_y} < SCR_H_L);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = empty_req ? S_DONE : S_DRAW;
      S_DRAW: if (last_px) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request capture, scan counters and registered pixel outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_r      <= '0;
      y0_r      <= '0;
      w_r       <= '0;
      h_r       <= '0;
      outline_r <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
    end else begin
      plot <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            x0_r      <= req_x;
            y0_r      <= req_y;
            w_r       <= req_w;
            h_r       <= req_h;
            outline_r <= req_outline;
            cx        <= '0;
            cy        <= '0;
            if (!empty_req) begin
              x      <= req_x;
              y      <= req_y;
              colour <= req_colour;
              plot   <= first_on;
            end
          end
        end
        S_DRAW: begin
          if (!last_px) begin
            cx   <= ncx;
            cy   <= ncy;
            x    <= sum_x[X_W-1:0];
            y    <= sum_y[Y_W-1:0];
            plot <= next_on && next_border;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Testbench for rect_plotter: directed scenarios plus randomized rectangles,
// each compared cycle by cycle against a queue of expected pixels produced
// by a nested-loop model of the rasterisation rules.
module tb_rect_plotter;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [X_W-1:0] req_x = '0;
  logic [Y_W-1:0] req_y = '0;
  logic [X_W-1:0] req_w = '0;
  logic [Y_W-1:0] req_h = '0;
  logic [C_W-1:0] req_colour = '0;
  logic           req_outline = 1'b0;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [C_W-1:0] colour;
  logic           plot;
  logic           busy;
  logic           done;
  logic [1:0]     dbg_state;

  rect_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .req_outline(req_outline),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: {plot, x, y, colour} per expected DRAW cycle
  logic [18:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: enumerate the rectangle directly from its definition
  task automatic build_model(input int rx, input int ry, input int rw, input int rh,
                             input int rc, input int ro);
    int px;
    int py;
    bit on;
    bit border;
    logic [18:0] e;
    exp_q.delete();
    for (int cy = 0; cy < rh; cy++) begin
      for (int cx = 0; cx < rw; cx++) begin
        px = rx + cx;
        py = ry + cy;
        on = (px < 160) && (py < 120);
        border = (ro == 0) || (cx == 0) || (cx == rw - 1) || (cy == 0) || (cy == rh - 1);
        e[18]    = on && border;
        e[17:10] = px[7:0];
        e[9:3]   = py[6:0];
        e[2:0]   = rc[2:0];
        exp_q.push_back(e);
      end
    end
  endtask

  // Driver tasks
  task automatic drive(input int rx, input int ry, input int rw, input int rh,
                       input int rc, input int ro);
    req_x       = rx[X_W-1:0];
    req_y       = ry[Y_W-1:0];
    req_w       = rw[X_W-1:0];
    req_h       = rh[Y_W-1:0];
    req_colour  = rc[C_W-1:0];
    req_outline = ro[0];
    req_valid   = 1'b1;
  endtask

  // Called at a negedge with a request driven; returns at the negedge
  // following the acceptance edge.
  task automatic wait_accept();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 1000), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks every DRAW cycle, the DONE cycle and the following IDLE cycle.
  task automatic check_rect(input int rx, input int ry, input int rw, input int rh,
                            input int rc, input int ro, input bit keep,
                            output int nplots);
    logic [18:0] e;
    build_model(rx, ry, rw, rh, rc, ro);
    nplots = 0;
    if (!keep) begin
      // Request withdrawn and fields scrambled: must not affect the draw
      req_valid   = 1'b0;
      req_x       = X_W'($urandom);
      req_y       = Y_W'($urandom);
      req_w       = X_W'($urandom);
      req_h       = Y_W'($urandom);
      req_colour  = C_W'($urandom);
      req_outline = 1'($urandom);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("draw_busy", 32'(busy), 32'd1);
      chk("draw_ready", 32'(req_ready), 32'd0);
      chk("draw_done", 32'(done), 32'd0);
      chk("draw_plot", 32'(plot), 32'(e[18]));
      if (e[18]) begin
        nplots++;
        chk("draw_x", 32'(x), 32'(e[17:10]));
        chk("draw_y", 32'(y), 32'(e[9:3]));
        chk("draw_colour", 32'(colour), 32'(e[2:0]));
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_plot", 32'(plot), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_plot", 32'(plot), 32'd0);
  endtask

  task automatic do_rect(input int rx, input int ry, input int rw, input int rh,
                         input int rc, input int ro, output int nplots);
    drive(rx, ry, rw, rh, rc, ro);
    wait_accept();
    check_rect(rx, ry, rw, rh, rc, ro, 1'b0, nplots);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int rx, ry, rw, rh;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic fill
    do_rect(10, 20, 3, 2, 5, 0, np);
    chk("fill_plots", 32'(np), 32'd6);

    // Empty rectangle
    do_rect(7, 7, 0, 5, 3, 0, np);
    chk("empty_plots", 32'(np), 32'd0);
    do_rect(7, 7, 4, 0, 3, 1, np);
    chk("empty_h_plots", 32'(np), 32'd0);

    // Clipping at the bottom-right corner
    do_rect(158, 118, 4, 4, 2, 0, np);
    chk("clip_plots", 32'(np), 32'd4);

    // Carry-out past the coordinate width
    do_rect(254, 126, 4, 3, 1, 0, np);
    chk("wrap_plots", 32'(np), 32'd0);

    // Outline
    do_rect(30, 40, 4, 3, 6, 1, np);
    chk("outline_plots", 32'(np), 32'd10);

    // Request held valid; a second request presented during the draw
    drive(20, 30, 3, 2, 1, 0);
    wait_accept();
    drive(40, 10, 2, 3, 4, 1);
    check_rect(20, 30, 3, 2, 1, 0, 1'b1, np);
    chk("held_a_plots", 32'(np), 32'd6);
    wait_accept();
    check_rect(40, 10, 2, 3, 4, 1, 1'b0, np);
    chk("held_b_plots", 32'(np), 32'd6);
    for (int i = 0; i < 5; i++) begin
      chk("held_no_redraw_plot", 32'(plot), 32'd0);
      chk("held_no_redraw_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Reset during pixel 3 of a 5x5 fill
    drive(50, 50, 5, 5, 6, 0);
    wait_accept();
    req_valid = 1'b0;
    chk("rst_mid_p0", 32'(plot), 32'd1);
    @(negedge clk);
    chk("rst_mid_p1x", 32'(x), 32'd51);
    @(negedge clk);
    chk("rst_mid_p2x", 32'(x), 32'd52);
    reset = 1'b0;
    #1;
    chk("rst_mid_plot", 32'(plot), 32'd0);
    chk("rst_mid_x", 32'(x), 32'd0);
    chk("rst_mid_y", 32'(y), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_nodone", 32'(done), 32'd0);
      chk("rst_mid_noplot", 32'(plot), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_done", 32'(done), 32'd0);
    do_rect(3, 4, 3, 3, 7, 1, np);
    chk("post_rst_plots", 32'(np), 32'd8);

    // Randomized rectangles, biased toward the screen edges
    for (int i = 0; i < 30; i++) begin
      rx = (i % 3 == 0) ? $urandom_range(140, 255) : $urandom_range(0, 159);
      ry = (i % 3 == 1) ? $urandom_range(105, 127) : $urandom_range(0, 119);
      rw = $urandom_range(0, 10);
      rh = $urandom_range(0, 8);
      do_rect(rx, ry, rw, rh, $urandom_range(0, 7), $urandom_range(0, 1), np);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
